memory_stage: RTL and testbench

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/memory_stage.sv | 143 ++++++++++++++
 tb/tb_memory_stage.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// memory_stage: MIPS-style memory pipeline stage with data-bus response tracking and load extraction
//
// Ports:
//   clk, resetn                       clock, asynchronous active-low reset
//   valid_i, pc_i, inst_i, ctrl_i,
//   result_i, eaddr_i, rdata2_i,
//   waddr_i                           execute-stage register outputs (rdata2_i = old rt)
//   data_data_ok, data_rdata          data-bus response strobe and load word
//   done_o                            current instruction may leave (execute stage's ready)
//   ready_i                           writeback accepts a new instruction
//   fwd_addr, fwd_data, fwd_ok        bypass to earlier stages
//   valid_o, pc_o, inst_o, ctrl_o,
//   waddr_o, result_o                 registered outputs to writeback
//
// Optional feature: define MEM_UNALIGNED_LWLR_EN for LWL/LWR merging; otherwise they return the word.

`ifndef I_MAX
`define I_MEM_R 0
`define I_MEM_W 1
`define I_WEX   2
`define I_LB    3
`define I_LBU   4
`define I_LH    5
`define I_LHU   6
`define I_LW    7
`define I_LWL   8
`define I_LWR   9
`define I_MAX   10
`endif

module memory_stage (
    input  logic              clk,
    input  logic              resetn,
    input  logic              valid_i,
    input  logic [31:0]       pc_i,
    input  logic [31:0]       inst_i,
    input  logic [`I_MAX-1:0] ctrl_i,
    input  logic [31:0]       result_i,
    input  logic [31:0]       eaddr_i,
    input  logic [31:0]       rdata2_i,
    input  logic [4:0]        waddr_i,
    input  logic              data_data_ok,
    input  logic [31:0]       data_rdata,
    output logic              done_o,
    input  logic              ready_i,
    output logic [4:0]        fwd_addr,
    output logic [31:0]       fwd_data,
    output logic              fwd_ok,
    output logic              valid_o,
    output logic [31:0]       pc_o,
    output logic [31:0]       inst_o,
    output logic [`I_MAX-1:0] ctrl_o,
    output logic [4:0]        waddr_o,
    output logic [31:0]       result_o
);
    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    state_t      state;
    logic        rbuf_valid;
    logic [31:0] rbuf_data;
    logic [31:0] hold_data;
    logic        mem_op, from_buf, rsp_to_op, buf_take, buf_load;
    logic [31:0] word, lwl, lwr, ld, res;
    logic [4:0]  sh;
    logic [7:0]  b;
    logic [15:0] h;
    logic        unused_bits;

    assign mem_op    = valid_i && (ctrl_i[`I_MEM_R] || ctrl_i[`I_MEM_W]);
    assign from_buf  = state == IDLE && rbuf_valid;
    // A response belongs to the current op when it is waiting, or when an op
    // arrives with an empty buffer and its response lands in the same cycle.
    assign rsp_to_op = data_data_ok && (state == WAIT || (state == IDLE && mem_op && !rbuf_valid));
    assign buf_take  = from_buf && mem_op && ready_i;
    // A full buffer only accepts new data in the cycle it is being drained.
    assign buf_load  = data_data_ok && !rsp_to_op && (!rbuf_valid || buf_take);
    assign done_o    = !mem_op || (resetn && (state == HOLD || from_buf || data_data_ok));

    assign word = state == HOLD ? hold_data : from_buf ? rbuf_data : data_rdata;
    assign sh   = {eaddr_i[1:0], 3'b000};
    assign b    = 8'(word >> sh);
    assign h    = eaddr_i[1] ? word[31:16] : word[15:0];

`ifdef MEM_UNALIGNED_LWLR_EN
    assign lwl = (word << (5'd24 - sh)) | (eaddr_i[1:0] == 2'd3 ? 32'd0 : rdata2_i & (32'hffffffff >> (sh + 5'd8)));
    assign lwr = (word >> sh) | (rdata2_i & ~(32'hffffffff >> sh));
    assign unused_bits = ^eaddr_i[31:2];
`else
    assign lwl = word;
    assign lwr = word;
    assign unused_bits = ^{eaddr_i[31:2], rdata2_i};
`endif

    assign ld = ctrl_i[`I_LB]  ? {{24{b[7]}}, b} :
                ctrl_i[`I_LBU] ? {24'd0, b} :
                ctrl_i[`I_LH]  ? {{16{h[15]}}, h} :
                ctrl_i[`I_LHU] ? {16'd0, h} :
                ctrl_i[`I_LWL] ? lwl :
                ctrl_i[`I_LWR] ? lwr : word;
    assign res = ctrl_i[`I_MEM_R] ? ld : result_i;

    assign fwd_addr = {5{valid_i}} & waddr_i;
    assign fwd_data = res;
    assign fwd_ok   = valid_i && done_o && (ctrl_i[`I_WEX] || ctrl_i[`I_MEM_R]) && waddr_i != 5'd0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            rbuf_valid <= 1'b0;
            rbuf_data  <= 32'd0;
            hold_data  <= 32'd0;
            valid_o    <= 1'b0;
            pc_o       <= 32'd0;
            inst_o     <= 32'd0;
            ctrl_o     <= '0;
            waddr_o    <= 5'd0;
            result_o   <= 32'd0;
        end else begin
            if (rsp_to_op)
                state <= ready_i ? IDLE : HOLD;
            else if (state == IDLE && mem_op && !rbuf_valid)
                state <= WAIT;
            else if (state == HOLD && ready_i)
                state <= IDLE;
            if (rsp_to_op && !ready_i)
                hold_data <= data_rdata;
            if (buf_take)
                rbuf_valid <= 1'b0;
            if (buf_load) begin
                rbuf_valid <= 1'b1;
                rbuf_data  <= data_rdata;
            end
            if (ready_i) begin
                valid_o  <= valid_i && done_o;
                pc_o     <= pc_i;
                inst_o   <= inst_i;
                ctrl_o   <= ctrl_i;
                waddr_o  <= waddr_i;
                result_o <= res;
            end
        end
    end
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed and randomized checks of memory_stage against a transaction-level model

`ifndef I_MAX
`define I_MEM_R 0
`define I_MEM_W 1
`define I_WEX   2
`define I_LB    3
`define I_LBU   4
`define I_LH    5
`define I_LHU   6
`define I_LW    7
`define I_LWL   8
`define I_LWR   9
`define I_MAX   10
`endif

module tb_memory_stage;
    localparam int K_ADD = 0, K_SW = 1, K_LB = 2, K_LBU = 3, K_LH = 4, K_LHU = 5, K_LW = 6, K_LWL = 7, K_LWR = 8;

    logic              clk = 0, resetn = 0;
    logic              valid_i = 0, data_data_ok = 0, ready_i = 0;
    logic [31:0]       pc_i = 0, inst_i = 0, result_i = 0, eaddr_i = 0, rdata2_i = 0, data_rdata = 0;
    logic [`I_MAX-1:0] ctrl_i = '0;
    logic [4:0]        waddr_i = 0;
    logic              done_o, fwd_ok, valid_o;
    logic [4:0]        fwd_addr, waddr_o;
    logic [31:0]       fwd_data, pc_o, inst_o, result_o;
    logic [`I_MAX-1:0] ctrl_o;
    int tests = 0, fails = 0;

    memory_stage dut (
        .clk(clk), .resetn(resetn), .valid_i(valid_i), .pc_i(pc_i), .inst_i(inst_i), .ctrl_i(ctrl_i),
        .result_i(result_i), .eaddr_i(eaddr_i), .rdata2_i(rdata2_i), .waddr_i(waddr_i),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata), .done_o(done_o), .ready_i(ready_i),
        .fwd_addr(fwd_addr), .fwd_data(fwd_data), .fwd_ok(fwd_ok), .valid_o(valid_o), .pc_o(pc_o),
        .inst_o(inst_o), .ctrl_o(ctrl_o), .waddr_o(waddr_o), .result_o(result_o)
    );

    always #5 clk = ~clk;

    function automatic logic [`I_MAX-1:0] mk(input int kind);
        logic [`I_MAX-1:0] c = '0;
        case (kind)
            K_ADD:   c[`I_WEX] = 1'b1;
            K_SW:    c[`I_MEM_W] = 1'b1;
            default: c[`I_MEM_R] = 1'b1;
        endcase
        case (kind)
            K_LB:  c[`I_LB] = 1'b1;
            K_LBU: c[`I_LBU] = 1'b1;
            K_LH:  c[`I_LH] = 1'b1;
            K_LHU: c[`I_LHU] = 1'b1;
            K_LW:  c[`I_LW] = 1'b1;
            K_LWL: c[`I_LWL] = 1'b1;
            K_LWR: c[`I_LWR] = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    function automatic logic [31:0] byte_of(input logic [31:0] x, input int j);
        return (x >> (8 * j)) & 32'hff;
    endfunction

    // Expected instruction result from the architectural load/store rules.
    function automatic logic [31:0] ref_result(input int kind, input int k, input logic [31:0] w,
                                               input logic [31:0] rd2, input logic [31:0] res);
        logic [31:0] bv = byte_of(w, k);
        logic [31:0] hv = (w >> (16 * (k / 2))) & 32'hffff;
        logic [31:0] r = 0;
        case (kind)
            K_LB:  return bv >= 128 ? bv + 32'hffffff00 : bv;
            K_LBU: return bv;
            K_LH:  return hv >= 32768 ? hv + 32'hffff0000 : hv;
            K_LHU: return hv;
            K_LW:  return w;
`ifdef MEM_UNALIGNED_LWLR_EN
            K_LWL: begin
                for (int i = 0; i < 4; i++)
                    if (i >= 3 - k) r = r | (byte_of(w, i - (3 - k)) << (8 * i));
                    else r = r | (byte_of(rd2, i) << (8 * i));
                return r;
            end
            K_LWR: begin
                for (int i = 0; i < 4; i++)
                    if (i <= 3 - k) r = r | (byte_of(w, i + k) << (8 * i));
                    else r = r | (byte_of(rd2, i) << (8 * i));
                return r;
            end
`else
            K_LWL, K_LWR: return w;
`endif
            default: return res;
        endcase
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_inst(input int kind, input logic [31:0] ea, input logic [4:0] wa, input logic [31:0] res);
        valid_i = 1; ctrl_i = mk(kind); eaddr_i = ea; waddr_i = wa; result_i = res;
        pc_i = $urandom; inst_i = $urandom;
    endtask

    task automatic go_idle;
        valid_i = 0; ctrl_i = '0; result_i = 0; data_data_ok = 0; ready_i = 1;
        step;
    endtask

    task automatic test_reset;
        resetn = 0;
        set_inst(K_LB, 32'h2, 5'd7, 32'h1);
        data_data_ok = 1; ready_i = 1;
        step;
        tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid_o: got %b want 0", valid_o); end
        tests++; if (result_o !== 32'd0) begin fails++; $display("FAIL reset_result_o: got %h want 0", result_o); end
        tests++; if (pc_o !== 32'd0 || waddr_o !== 5'd0) begin fails++; $display("FAIL reset_pc_waddr: got %h %0d want 0 0", pc_o, waddr_o); end
        tests++; if (done_o !== 1'b0) begin fails++; $display("FAIL reset_done_mem: got %b want 0", done_o); end
        tests++; if (fwd_addr !== 5'd7) begin fails++; $display("FAIL reset_fwd_addr: got %0d want 7", fwd_addr); end
        valid_i = 0; #1;
        tests++; if (fwd_addr !== 5'd0) begin fails++; $display("FAIL reset_fwd_addr_inv: got %0d want 0", fwd_addr); end
        data_data_ok = 0; resetn = 1;
        go_idle;
    endtask

    task automatic test_lb_wait;
        set_inst(K_LB, 32'h1000_0002, 5'd9, 32'h0); ready_i = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++; if (done_o !== 1'b0) begin fails++; $display("FAIL lb_wait_done[%0d]: got %b want 0", i, done_o); end
            step;
        end
        data_data_ok = 1; data_rdata = 32'h12F45678; #1;
        tests++; if (done_o !== 1'b1 || fwd_ok !== 1'b1) begin fails++; $display("FAIL lb_ok_done: got done=%b fwd_ok=%b want 1 1", done_o, fwd_ok); end
        tests++; if (fwd_data !== 32'hFFFFFFF4) begin fails++; $display("FAIL lb_fwd_data: got %h want fffffff4", fwd_data); end
        step;
        data_data_ok = 0;
        tests++; if (result_o !== 32'hFFFFFFF4 || valid_o !== 1'b1) begin fails++; $display("FAIL lb_result_o: got %h v=%b want fffffff4 v=1", result_o, valid_o); end
        go_idle;
    endtask

    task automatic test_hold;
        set_inst(K_LHU, 32'h2000_0002, 5'd4, 32'h0); ready_i = 0;
        step;
        data_data_ok = 1; data_rdata = 32'h89AB0000; #1;
        tests++; if (done_o !== 1'b1) begin fails++; $display("FAIL hold_ok_done: got %b want 1", done_o); end
        step;
        data_data_ok = 0;
        for (int i = 0; i < 3; i++) begin
            data_rdata = $urandom; #1;
            tests++; if (done_o !== 1'b1 || fwd_data !== 32'h000089AB) begin fails++; $display("FAIL hold_keep[%0d]: got done=%b data=%h want 1 000089ab", i, done_o, fwd_data); end
            tests++; if (valid_o !== 1'b0 || result_o !== 32'd0) begin fails++; $display("FAIL hold_no_update[%0d]: got v=%b r=%h want 0 0", i, valid_o, result_o); end
            step;
        end
        ready_i = 1;
        step;
        tests++; if (result_o !== 32'h000089AB || valid_o !== 1'b1) begin fails++; $display("FAIL hold_release: got %h v=%b want 000089ab v=1", result_o, valid_o); end
        go_idle;
    endtask

    task automatic test_rbuf;
        data_data_ok = 1; data_rdata = 32'hCAFEBABE;
        step;
        data_data_ok = 0; data_rdata = 32'h0;
        set_inst(K_LW, 32'h3000_0000, 5'd6, 32'h0); #1;
        tests++; if (done_o !== 1'b1 || fwd_data !== 32'hCAFEBABE) begin fails++; $display("FAIL rbuf_done: got done=%b data=%h want 1 cafebabe", done_o, fwd_data); end
        step;
        tests++; if (result_o !== 32'hCAFEBABE || valid_o !== 1'b1) begin fails++; $display("FAIL rbuf_result_o: got %h v=%b want cafebabe v=1", result_o, valid_o); end
        set_inst(K_LW, 32'h3000_0004, 5'd6, 32'h0); #1;
        tests++; if (done_o !== 1'b0) begin fails++; $display("FAIL rbuf_cleared: got %b want 0", done_o); end
        step;
        data_data_ok = 1; data_rdata = 32'h01020304; step; data_data_ok = 0;
        go_idle;
        // Second response with a full buffer is dropped; the first one survives.
        valid_i = 0; data_data_ok = 1; data_rdata = 32'hAAAA0001; step;
        data_rdata = 32'hBBBB0002; step;
        data_data_ok = 0;
        set_inst(K_LW, 32'h0, 5'd1, 32'h0); #1;
        tests++; if (done_o !== 1'b1 || fwd_data !== 32'hAAAA0001) begin fails++; $display("FAIL rbuf_overflow: got done=%b data=%h want 1 aaaa0001", done_o, fwd_data); end
        step;
        go_idle;
    endtask

    task automatic test_nonmem;
        set_inst(K_ADD, 32'h0, 5'd3, 32'h5); ready_i = 0; #1;
        tests++; if (done_o !== 1'b1 || fwd_ok !== 1'b1 || fwd_addr !== 5'd3) begin fails++; $display("FAIL add_fwd: got done=%b ok=%b addr=%0d want 1 1 3", done_o, fwd_ok, fwd_addr); end
        ready_i = 1;
        step;
        tests++; if (result_o !== 32'h5 || valid_o !== 1'b1 || waddr_o !== 5'd3) begin fails++; $display("FAIL add_result_o: got %h v=%b wa=%0d want 5 1 3", result_o, valid_o, waddr_o); end
        waddr_i = 0; #1;
        tests++; if (fwd_ok !== 1'b0) begin fails++; $display("FAIL add_r0_fwd_ok: got %b want 0", fwd_ok); end
        set_inst(K_SW, 32'h4, 5'd0, 32'h77); #1;
        tests++; if (done_o !== 1'b0) begin fails++; $display("FAIL sw_wait: got %b want 0", done_o); end
        data_data_ok = 1; #1;
        tests++; if (done_o !== 1'b1 || fwd_data !== 32'h77) begin fails++; $display("FAIL sw_ack: got done=%b data=%h want 1 77", done_o, fwd_data); end
        step;
        go_idle;
    endtask

    task automatic test_reset_wait;
        set_inst(K_ADD, 32'h0, 5'd2, 32'h9); step;
        set_inst(K_LW, 32'h0, 5'd5, 32'h0); ready_i = 0; step;
        resetn = 0; #1;
        tests++; if (valid_o !== 1'b0 || result_o !== 32'd0) begin fails++; $display("FAIL rst_wait_clear: got v=%b r=%h want 0 0", valid_o, result_o); end
        valid_i = 0; step;
        resetn = 1; step;
        data_data_ok = 1; data_rdata = 32'h0BADF00D; step;
        data_data_ok = 0; data_rdata = 0;
        set_inst(K_LW, 32'h0, 5'd5, 32'h0); ready_i = 1; #1;
        tests++; if (done_o !== 1'b1 || fwd_data !== 32'h0BADF00D) begin fails++; $display("FAIL rst_late_rbuf: got done=%b data=%h want 1 0badf00d", done_o, fwd_data); end
        step;
        go_idle;
    endtask

    task automatic test_lwlr;
        logic [31:0] want;
        rdata2_i = 32'hAABBCCDD;
        for (int kind = K_LWL; kind <= K_LWR; kind++) begin
`ifdef MEM_UNALIGNED_LWLR_EN
            want = kind == K_LWL ? 32'h3344CCDD : 32'hAA112233;
`else
            want = 32'h11223344;
`endif
            set_inst(kind, 32'h5001, 5'd8, 32'h0);
            data_data_ok = 1; data_rdata = 32'h11223344; #1;
            tests++; if (fwd_data !== want) begin fails++; $display("FAIL lwlr_kind%0d: got %h want %h", kind, fwd_data, want); end
            step;
            tests++; if (result_o !== want) begin fails++; $display("FAIL lwlr_result_o_kind%0d: got %h want %h", kind, result_o, want); end
            go_idle;
        end
    endtask

    task automatic test_random;
        int kind, k, delay, cyc;
        bit ismem, early, got, okn, exp_done, r, left;
        logic [31:0] w, exp;
        logic [4:0] wa;
        for (int n = 0; n < 150; n++) begin
            kind = $urandom_range(0, 8); ismem = kind != K_ADD;
            early = ismem && $urandom_range(0, 3) == 0;
            delay = $urandom_range(0, 3);
            w = $urandom; wa = 5'($urandom_range(0, 31)); k = $urandom_range(0, 3);
            if (early || $urandom_range(0, 1) == 1) begin
                valid_i = 0; ctrl_i = '0; data_data_ok = early; data_rdata = early ? w : $urandom;
                ready_i = $urandom_range(0, 1) == 1; r = ready_i;
                step;
                data_data_ok = 0;
                if (r) begin tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL rnd_idle_valid[%0d]: got %b want 0", n, valid_o); end end
            end
            set_inst(kind, {$urandom_range(0, 65535), 14'd0, 2'(k)}, wa, $urandom);
            rdata2_i = $urandom;
            exp = ref_result(kind, k, w, rdata2_i, result_i);
            got = early; cyc = 0; left = 0;
            while (!left && cyc < 40) begin
                okn = ismem && !got && cyc >= delay;
                data_data_ok = okn; data_rdata = okn ? w : $urandom;
                ready_i = $urandom_range(0, 3) != 0; r = ready_i;
                exp_done = !ismem || got || okn;
                #1;
                tests++; if (done_o !== exp_done) begin fails++; $display("FAIL rnd_done[%0d]: got %b want %b", n, done_o, exp_done); end
                if (exp_done) begin
                    tests++; if (fwd_data !== exp || fwd_ok !== (kind != K_SW && wa != 0)) begin fails++; $display("FAIL rnd_fwd[%0d]: got %h ok=%b want %h ok=%b", n, fwd_data, fwd_ok, exp, kind != K_SW && wa != 0); end
                end
                step;
                got = got || okn; cyc++;
                if (r) begin
                    tests++; if (valid_o !== exp_done || (exp_done && result_o !== exp)) begin fails++; $display("FAIL rnd_out[%0d]: got v=%b r=%h want v=%b r=%h", n, valid_o, result_o, exp_done, exp); end
                    left = exp_done;
                end
            end
            data_data_ok = 0;
            if (!left) begin tests++; fails++; $display("FAIL rnd_timeout[%0d]: instruction never left the stage", n); end
        end
        go_idle;
    endtask

    initial begin
        test_reset;
        test_lb_wait;
        test_hold;
        test_rbuf;
        test_nonmem;
        test_reset_wait;
        test_lwlr;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
